tinytpu_loader: RTL
===================

# tinytpu_loader

Host-side transmitter for the tinytpu serial operand link. Accepts D_W-bit X/Y operand pairs over a valid/ready handshake and serializes them MSB-first onto the data_in_x / data_in_y / load_en wires. After N*N pairs it issues the one-cycle init pulse that starts the array. It sits in front of tinytpu_top in system and test harnesses and drives exactly the serial inputs that block receives.

## Interface
- D_W, 8, operand element width in bits (≥2)
- N, 2, array dimension; one frame = N*N element pairs

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream offers a pair
- in_ready  out  1  loader can accept a pair this cycle
- in_x  in  D_W  X operand element
- in_y  in  D_W  Y operand element
- tx_x  out  1  serial X bit (to data_in_x)
- tx_y  out  1  serial Y bit (to data_in_y)
- tx_load_en  out  1  tx_x/tx_y carry a valid bit this cycle (to load_en)
- tx_init  out  1  one-cycle compute start (to init)
- busy  out  1  frame in progress (first accept through init cycle)
- done  out  1  one-cycle pulse, coincident with tx_init

## Operation
- Transfer occurs on a rising edge where in_valid & in_ready.
- Storage: shift pair (shift_x, shift_y) plus bit counter; one-deep hold pair with hold_valid; accept counter (0..N*N); element-sent counter (0..N*N).
- in_ready = ~hold_valid & (accept count < N*N) & state != INIT.
- Shift slot is free when idle or on its last bit (bit count = D_W-1). At each edge where the slot is free: load from hold if hold_valid (clear hold_valid), else load the pair accepted this edge; otherwise an accepted pair goes to hold.
- While shifting: tx_load_en=1, tx_x=shift_x[D_W-1], tx_y=shift_y[D_W-1]; shift left by one each cycle, bit count increments, wraps to 0 after D_W-1 and element-sent count increments.
- tx_load_en=0 whenever no element is shifting (upstream starvation gaps allowed); tx_x=tx_y=0 when tx_load_en=0.
- States: IDLE (no frame) -> LOAD on first accept -> INIT after last bit of the N*N-th element -> IDLE next cycle.
- INIT: tx_init=1, done=1, tx_load_en=0, counters cleared. Exactly one cycle.
- Accepts beyond N*N in a frame are blocked (in_ready=0) until IDLE.
- in_x/in_y sampled only on transfer; later changes are ignored.

## Timing
- Reset (async assert, sync release): in_ready=1, tx_x=tx_y=tx_load_en=tx_init=busy=done=0, state IDLE, all counters and hold_valid cleared.
- Latency: pair accepted in cycle c with slot free -> its MSB on tx_x/tx_y in cycle c+1, LSB in c+D_W.
- Back-to-back: with pairs available whenever in_ready=1, tx_load_en stays high for N*N*D_W consecutive cycles with no gap.
- tx_init asserted the cycle after the last LSB; in_ready returns high the cycle after tx_init.
- busy rises the cycle after the first accept, falls the cycle after tx_init.
- Reset mid-frame: frame discarded, no tx_init, outputs to reset values immediately.
- in_valid held high with in_ready=0: no state change, pair not consumed.

## Test plan
- Single frame, D_W=8, N=2, pairs (x,y)=(0x81,0x01),(0x7E,0xFF),(0x00,0xAA),(0x55,0x80) presented continuously from cycle 0 -> tx_load_en high cycles 1..32, tx_x bits 1000_0001 0111_1110 0000_0000 0101_0101 MSB-first, tx_y matching, tx_init=done=1 only in cycle 33, in_ready high again cycle 34.
- Starved upstream: 3-cycle gap before pair 2 -> tx_load_en low during the gap, tx_x=tx_y=0, bit stream unchanged otherwise, tx_init one cycle after final LSB.
- Backpressure: in_valid held high throughout -> exactly 4 transfers per frame, in_ready low from after 4th accept through cycle 33, second frame starts cleanly at cycle 34.
- Hold buffer: second pair offered while first shifts -> accepted into hold in cycle 1, in_ready=0 cycles 2..8, pair 2 MSB appears cycle 9.
- Async reset at cycle 15 of a frame -> outputs go to reset values without a clock edge, no tx_init; new frame after release serializes correctly from first bit.
- Random frames (1000) vs. bit-level reference model, including random gaps and in_valid toggling -> serial streams and init position match exactly.

Source files
------------

// File: rtl/tinytpu_loader.sv
// Host-side serializer for the tinytpu operand link: accepts X/Y element pairs and
// shifts them out MSB-first, then pulses init once a full N*N frame has been sent.
module tinytpu_loader #(
    parameter int D_W = 8,
    parameter int N   = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [D_W-1:0] in_x,
    input  logic [D_W-1:0] in_y,
    output logic           tx_x,
    output logic           tx_y,
    output logic           tx_load_en,
    output logic           tx_init,
    output logic           busy,
    output logic           done
);

    localparam int NUM   = N * N;
    localparam int CNT_W = $clog2(NUM + 1);
    localparam int BIT_W = $clog2(D_W);

    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(D_W - 1);
    localparam logic [CNT_W-1:0] NUM_C     = CNT_W'(NUM);
    localparam logic [CNT_W-1:0] LAST_ELEM = CNT_W'(NUM - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        INIT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [D_W-1:0]   shift_x;
    logic [D_W-1:0]   shift_y;
    logic [D_W-1:0]   hold_x;
    logic [D_W-1:0]   hold_y;
    logic             hold_valid;
    logic             shifting;
    logic [BIT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] acc_cnt;
    logic [CNT_W-1:0] sent_cnt;

    logic fire;
    logic on_last_bit;
    logic slot_free;
    logic frame_sent;

    assign fire        = in_valid & in_ready;
    assign on_last_bit = shifting & (bit_cnt == LAST_BIT);
    assign slot_free   = ~shifting | on_last_bit;
    assign frame_sent  = on_last_bit & (sent_cnt == LAST_ELEM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every variable assigned in a combinational block gets a default first,
    // otherwise an unassigned path makes synthesis infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (fire) state_nxt = LOAD;
            LOAD:    if (frame_sent) state_nxt = INIT;
            INIT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = ~hold_valid & (acc_cnt < NUM_C) & (state != INIT);
        tx_load_en = shifting;
        tx_x       = shifting & shift_x[D_W-1];
        tx_y       = shifting & shift_y[D_W-1];
        tx_init    = (state == INIT);
        done       = (state == INIT);
        busy       = (state != IDLE);
    end

    // NOTE: non-blocking assignments only; where two assignments to the same register
    // fire on one edge, the later one wins, which lets a fresh load override the shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_x    <= '0;
            shift_y    <= '0;
            hold_x     <= '0;
            hold_y     <= '0;
            hold_valid <= 1'b0;
            shifting   <= 1'b0;
            bit_cnt    <= '0;
            acc_cnt    <= '0;
            sent_cnt   <= '0;
        end else if (state == INIT) begin
            acc_cnt  <= '0;
            sent_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            if (fire) begin
                acc_cnt <= acc_cnt + CNT_W'(1);
            end
            if (shifting) begin
                shift_x <= shift_x << 1;
                shift_y <= shift_y << 1;
                if (on_last_bit) begin
                    bit_cnt  <= '0;
                    sent_cnt <= sent_cnt + CNT_W'(1);
                end else begin
                    bit_cnt <= bit_cnt + BIT_W'(1);
                end
            end
            // The hold pair always has priority: in_ready is low while it is occupied.
            if (slot_free) begin
                if (hold_valid) begin
                    shift_x    <= hold_x;
                    shift_y    <= hold_y;
                    shifting   <= 1'b1;
                    hold_valid <= 1'b0;
                end else if (fire) begin
                    shift_x  <= in_x;
                    shift_y  <= in_y;
                    shifting <= 1'b1;
                end else begin
                    shifting <= 1'b0;
                end
            end else if (fire) begin
                hold_x     <= in_x;
                hold_y     <= in_y;
                hold_valid <= 1'b1;
            end
        end
    end

endmodule
